keypad_lock_ctrl: RTL and testbench

Controller that consumes decoded key events from the 4x4 matrix keypad scanner and sequences a 4-digit code-lock.
- Assembles typed digits into a BCD entry buffer and handles clear, backspace and enter keys.
- Compares the entry against a stored code, drives unlocked/alarm status and enforces a timed lockout after repeated failures.
- Sits between the keypad scanner (Value/flag outputs) and the display/actuator logic.

---
 rtl/keypad_lock_ctrl_if.sv | 25 ++
 rtl/keypad_lock_ctrl.sv | 166 ++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad lock controller bus: scanner key events in, entry/status/pulse outputs back.
// The master side is the scanner/display side. The slave side is the lock controller.
interface keypad_lock_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  key_flag;
  logic [3:0]            key_value;
  logic [4*DIGITS-1:0]   entry;
  logic [2:0]            entry_cnt;
  logic                  unlocked;
  logic                  alarm;
  logic                  ok_pulse;
  logic                  err_pulse;
  logic [1:0]            fail_cnt;

  modport master (
    output key_flag, key_value,
    input  entry, entry_cnt, unlocked, alarm, ok_pulse, err_pulse, fail_cnt
  );

  modport slave (
    input  key_flag, key_value,
    output entry, entry_cnt, unlocked, alarm, ok_pulse, err_pulse, fail_cnt
  );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// 4-digit code lock: builds a BCD entry from scanner key events, checks it against the stored code,
// handles code change while open, idle auto-relock and a timed lockout after repeated failures.
module keypad_lock_ctrl #(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] INIT_CODE   = 16'h1234,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCK_CYCLES = 1000,
  parameter int                  OPEN_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_lock_ctrl_if.slave  bus
);

  localparam logic [3:0] KEY_CLR = 4'd10;
  localparam logic [3:0] KEY_BS  = 4'd11;
  localparam logic [3:0] KEY_ENT = 4'd12;
  localparam logic [2:0] FULL    = 3'(DIGITS);
  localparam int         TMAX    = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int         TW      = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {S_LOCKED, S_OPEN, S_LOCKOUT} state_e;

  state_e              state_q;
  logic                flag_q;
  logic                armed_q;
  logic [4*DIGITS-1:0] entry_q, entry_d;
  logic [2:0]          entryCnt_q, entryCnt_d;
  logic [4*DIGITS-1:0] code_q;
  logic [1:0]          failCnt_q;
  logic [TW-1:0]       timer_q;
  logic                unlocked_q, alarm_q, ok_q, err_q;
  logic                keyEvent;
  logic                isFull;
  logic [1:0]          failInc;

  // armed_q masks the first cycle after reset so a key already held at release is not an event
  assign keyEvent = armed_q & bus.key_flag & ~flag_q;
  assign isFull   = (entryCnt_q == FULL);
  assign failInc  = failCnt_q + 2'd1;

  always_comb begin
    entry_d    = entry_q;
    entryCnt_d = entryCnt_q;
    if (bus.key_value <= 4'd9) begin
      if (entryCnt_q < FULL) begin
        entry_d    = {entry_q[4*DIGITS-5:0], bus.key_value};
        entryCnt_d = entryCnt_q + 3'd1;
      end
    end else if (bus.key_value == KEY_BS) begin
      if (entryCnt_q != 3'd0) begin
        entry_d    = entry_q >> 4;
        entryCnt_d = entryCnt_q - 3'd1;
      end
    end else if (bus.key_value == KEY_CLR) begin
      entry_d    = '0;
      entryCnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOCKED;
      flag_q     <= 1'b0;
      armed_q    <= 1'b0;
      entry_q    <= '0;
      entryCnt_q <= '0;
      code_q     <= INIT_CODE;
      failCnt_q  <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      flag_q  <= bus.key_flag;
      armed_q <= 1'b1;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_LOCKED: begin
          if (keyEvent) begin
            if (bus.key_value == KEY_ENT) begin
              entry_q    <= '0;
              entryCnt_q <= '0;
              if (!isFull) begin
                err_q <= 1'b1;
              end else if (entry_q == code_q) begin
                state_q    <= S_OPEN;
                unlocked_q <= 1'b1;
                ok_q       <= 1'b1;
                failCnt_q  <= '0;
                timer_q    <= OPEN_LOAD;
              end else begin
                err_q     <= 1'b1;
                failCnt_q <= failInc;
                if (failInc == 2'(MAX_FAIL)) begin
                  state_q <= S_LOCKOUT;
                  alarm_q <= 1'b1;
                  timer_q <= LOCK_LOAD;
                end
              end
            end else begin
              entry_q    <= entry_d;
              entryCnt_q <= entryCnt_d;
            end
          end
        end
        S_OPEN: begin
          // Any key event restarts the idle timer, so expiry only happens in quiet cycles
          if (keyEvent) begin
            timer_q <= OPEN_LOAD;
            if (bus.key_value == KEY_ENT) begin
              entry_q    <= '0;
              entryCnt_q <= '0;
              if (isFull) begin
                code_q <= entry_q;
                ok_q   <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else if (bus.key_value == KEY_CLR && entryCnt_q == 3'd0) begin
              state_q    <= S_LOCKED;
              unlocked_q <= 1'b0;
            end else begin
              entry_q    <= entry_d;
              entryCnt_q <= entryCnt_d;
            end
          end else if (timer_q == '0) begin
            state_q    <= S_LOCKED;
            unlocked_q <= 1'b0;
            entry_q    <= '0;
            entryCnt_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q   <= S_LOCKED;
            alarm_q   <= 1'b0;
            failCnt_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q    <= S_LOCKED;
          unlocked_q <= 1'b0;
          alarm_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.entry     = entry_q;
  assign bus.entry_cnt = entryCnt_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.alarm     = alarm_q;
  assign bus.ok_pulse  = ok_q;
  assign bus.err_pulse = err_q;
  assign bus.fail_cnt  = failCnt_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random key sequences
// checked against a digit-queue model of the lock.
module tb_keypad_lock_ctrl;

  localparam int LOCK = 1000;
  localparam int OPEN = 500;
  localparam int MAXF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  keypad_lock_ctrl_if #(.DIGITS(4)) bus ();

  keypad_lock_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lock model: typed digits as a queue, stored code as a number
  int mDigits[$];
  int mCode;
  bit mOpen;
  bit mLockout;
  int mFails;

  function automatic int mEntry();
    int v = 0;
    foreach (mDigits[i]) v = v * 16 + mDigits[i];
    return v;
  endfunction

  function automatic void modelKey(input int k, output int eOk, output int eErr);
    eOk = 0;
    eErr = 0;
    if (mLockout) return;
    if (k <= 9) begin
      if (mDigits.size() < 4) mDigits.push_back(k);
    end else if (k == 11) begin
      if (mDigits.size() > 0) void'(mDigits.pop_back());
    end else if (k == 10) begin
      if (mOpen && mDigits.size() == 0) mOpen = 0;
      mDigits.delete();
    end else if (k == 12) begin
      if (mDigits.size() != 4) eErr = 1;
      else if (mOpen) begin
        mCode = mEntry();
        eOk = 1;
      end else if (mEntry() == mCode) begin
        mOpen = 1;
        mFails = 0;
        eOk = 1;
      end else begin
        eErr = 1;
        mFails++;
        if (mFails == MAXF) mLockout = 1;
      end
      mDigits.delete();
    end
  endfunction

  task automatic applyReset();
    bus.key_flag  = 1'b0;
    bus.key_value = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Press for 'hold' cycles then release; counts pulses seen over the whole press
  task automatic pressKey(input logic [3:0] k, input int hold, output int okN, output int errN);
    okN = 0;
    errN = 0;
    @(negedge clk);
    bus.key_value = k;
    bus.key_flag  = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      okN += int'(bus.ok_pulse);
      errN += int'(bus.err_pulse);
    end
    bus.key_flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      okN += int'(bus.ok_pulse);
      errN += int'(bus.err_pulse);
    end
  endtask

  task automatic enterCode(input logic [15:0] c, output int okN, output int errN);
    logic [15:0] cc;
    int o, e;
    cc = c;
    for (int i = 3; i >= 0; i--) pressKey(cc[4*i +: 4], 20, o, e);
    pressKey(4'd12, 20, okN, errN);
  endtask

  task automatic test_reset();
    applyReset();
    testsRun++;
    if ({bus.entry, bus.entry_cnt, bus.unlocked, bus.alarm, bus.ok_pulse, bus.err_pulse, bus.fail_cnt} !== 26'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got entry=%h cnt=%0d unl=%b alm=%b ok=%b err=%b fail=%0d expected all 0",
               bus.entry, bus.entry_cnt, bus.unlocked, bus.alarm, bus.ok_pulse, bus.err_pulse, bus.fail_cnt);
    end
  endtask

  task automatic test_unlock();
    int okN, errN;
    int expEntry = 0;
    for (int d = 1; d <= 4; d++) begin
      pressKey(4'(d), 20, okN, errN);
      expEntry = expEntry * 16 + d;
      testsRun++;
      if (bus.entry !== 16'(expEntry) || bus.entry_cnt !== 3'(d)) begin
        testsFailed++;
        $display("[TB] FAIL unlock_digit%0d got %h/%0d expected %h/%0d", d, bus.entry, bus.entry_cnt, expEntry, d);
      end
    end
    pressKey(4'd12, 20, okN, errN);
    testsRun++;
    if (okN !== 1 || errN !== 0 || bus.unlocked !== 1'b1 || bus.entry !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL unlock_enter got ok=%0d err=%0d unl=%b entry=%h expected ok=1 err=0 unl=1 entry=0000",
               okN, errN, bus.unlocked, bus.entry);
    end
    pressKey(4'd10, 20, okN, errN);
    testsRun++;
    if (bus.unlocked !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL unlock_clear_relock got unl=%b expected 0", bus.unlocked);
    end
  endtask

  task automatic test_backspace();
    int okN, errN;
    pressKey(4'd1, 20, okN, errN);
    pressKey(4'd2, 20, okN, errN);
    pressKey(4'd5, 20, okN, errN);
    pressKey(4'd11, 20, okN, errN);
    testsRun++;
    if (bus.entry !== 16'h0012 || bus.entry_cnt !== 3'd2) begin
      testsFailed++;
      $display("[TB] FAIL backspace got %h/%0d expected 0012/2", bus.entry, bus.entry_cnt);
    end
    pressKey(4'd3, 20, okN, errN);
    pressKey(4'd4, 20, okN, errN);
    pressKey(4'd9, 20, okN, errN);
    testsRun++;
    if (bus.entry !== 16'h1234 || bus.entry_cnt !== 3'd4) begin
      testsFailed++;
      $display("[TB] FAIL fifth_digit_ignored got %h/%0d expected 1234/4", bus.entry, bus.entry_cnt);
    end
    pressKey(4'd12, 20, okN, errN);
    testsRun++;
    if (okN !== 1 || bus.unlocked !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL backspace_unlock got ok=%0d unl=%b expected ok=1 unl=1", okN, bus.unlocked);
    end
    pressKey(4'd10, 20, okN, errN);
  endtask

  task automatic test_code_change();
    int okN, errN;
    enterCode(16'h1234, okN, errN);
    enterCode(16'h5678, okN, errN);
    testsRun++;
    if (okN !== 1 || errN !== 0 || bus.unlocked !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL code_change got ok=%0d err=%0d unl=%b expected 1 0 1", okN, errN, bus.unlocked);
    end
    pressKey(4'd10, 20, okN, errN);
    testsRun++;
    if (bus.unlocked !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clear_empty_relock got unl=%b expected 0", bus.unlocked);
    end
    enterCode(16'h1234, okN, errN);
    testsRun++;
    if (errN !== 1 || okN !== 0 || bus.unlocked !== 1'b0 || bus.fail_cnt !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL old_code_rejected got err=%0d ok=%0d unl=%b fail=%0d expected 1 0 0 1",
               errN, okN, bus.unlocked, bus.fail_cnt);
    end
    enterCode(16'h5678, okN, errN);
    testsRun++;
    if (okN !== 1 || bus.unlocked !== 1'b1 || bus.fail_cnt !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL new_code_unlock got ok=%0d unl=%b fail=%0d expected 1 1 0", okN, bus.unlocked, bus.fail_cnt);
    end
    pressKey(4'd10, 20, okN, errN);
  endtask

  task automatic test_auto_relock();
    int okN, errN;
    int openCycles = 0;
    enterCode(16'h5678, okN, errN);
    @(negedge clk);
    bus.key_value = 4'd7;
    bus.key_flag  = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 2 * OPEN; t++) begin
      @(negedge clk);
      if (t == 3) bus.key_flag = 1'b0;
      if (bus.unlocked === 1'b1) openCycles++;
      else break;
    end
    testsRun++;
    if (openCycles !== OPEN) begin
      testsFailed++;
      $display("[TB] FAIL auto_relock_time got %0d cycles expected %0d", openCycles, OPEN);
    end
    testsRun++;
    if (bus.entry !== 16'h0 || bus.entry_cnt !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL auto_relock_clear got %h/%0d expected 0000/0", bus.entry, bus.entry_cnt);
    end
  endtask

  task automatic test_lockout();
    int okN, errN;
    int o, e;
    int alarmCycles = 0;
    int bad = 0;
    logic firstErr = 1'b0;
    logic [1:0] firstFail = 2'd0;
    for (int i = 1; i <= 2; i++) begin
      enterCode(16'h9999, okN, errN);
      testsRun++;
      if (errN !== 1 || bus.fail_cnt !== 2'(i) || bus.alarm !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL wrong_code%0d got err=%0d fail=%0d alm=%b expected 1 %0d 0", i, errN, bus.fail_cnt, bus.alarm, i);
      end
    end
    for (int i = 0; i < 4; i++) pressKey(4'd9, 20, o, e);
    @(negedge clk);
    bus.key_value = 4'd12;
    bus.key_flag  = 1'b1;
    @(posedge clk);
    for (int t = 0; t < LOCK + 100; t++) begin
      @(negedge clk);
      if (t == 0) begin
        firstErr  = bus.err_pulse;
        firstFail = bus.fail_cnt;
      end
      if (bus.alarm !== 1'b1) break;
      alarmCycles++;
      if (bus.entry !== 16'h0 || bus.entry_cnt !== 3'd0) bad++;
      bus.key_value = 4'd1;
      bus.key_flag  = (t < LOCK - 20) ? ((t % 10) < 5) : 1'b0;
    end
    bus.key_flag = 1'b0;
    testsRun++;
    if (firstErr !== 1'b1 || firstFail !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL third_wrong got err=%b fail=%0d expected 1 3", firstErr, firstFail);
    end
    testsRun++;
    if (alarmCycles !== LOCK || bad !== 0) begin
      testsFailed++;
      $display("[TB] FAIL lockout_duration got %0d cycles, %0d key leaks expected %0d cycles, 0 leaks", alarmCycles, bad, LOCK);
    end
    testsRun++;
    if (bus.alarm !== 1'b0 || bus.fail_cnt !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL lockout_exit got alm=%b fail=%0d expected 0 0", bus.alarm, bus.fail_cnt);
    end
  endtask

  task automatic test_reset_mid_lockout();
    int okN, errN;
    for (int i = 0; i < 3; i++) enterCode(16'h9999, okN, errN);
    testsRun++;
    if (bus.alarm !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL lockout_before_reset got alm=%b expected 1", bus.alarm);
    end
    @(negedge clk);
    bus.key_value = 4'd5;
    bus.key_flag  = 1'b1;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if ({bus.entry, bus.entry_cnt, bus.unlocked, bus.alarm, bus.ok_pulse, bus.err_pulse, bus.fail_cnt} !== 26'd0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset got entry=%h alm=%b fail=%0d expected all 0", bus.entry, bus.alarm, bus.fail_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    testsRun++;
    if (bus.entry !== 16'h0 || bus.entry_cnt !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL held_key_after_reset got %h/%0d expected 0000/0", bus.entry, bus.entry_cnt);
    end
    bus.key_flag = 1'b0;
    repeat (3) @(negedge clk);
    pressKey(4'd5, 20, okN, errN);
    testsRun++;
    if (bus.entry !== 16'h0005) begin
      testsFailed++;
      $display("[TB] FAIL repress_after_reset got %h expected 0005", bus.entry);
    end
    pressKey(4'd10, 20, okN, errN);
    enterCode(16'h1234, okN, errN);
    testsRun++;
    if (okN !== 1 || bus.unlocked !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL init_code_restored got ok=%0d unl=%b expected 1 1", okN, bus.unlocked);
    end
  endtask

  task automatic randStep(input int k);
    int okN, errN, eOk, eErr;
    pressKey(4'(k), $urandom_range(1, 6), okN, errN);
    modelKey(k, eOk, eErr);
    testsRun++;
    if (bus.entry !== 16'(mEntry()) || bus.entry_cnt !== 3'(mDigits.size())) begin
      testsFailed++;
      $display("[TB] FAIL rand_entry key=%0d got %h/%0d expected %h/%0d", k, bus.entry, bus.entry_cnt, mEntry(), mDigits.size());
    end
    testsRun++;
    if (bus.unlocked !== mOpen || bus.alarm !== mLockout || bus.fail_cnt !== 2'(mFails)) begin
      testsFailed++;
      $display("[TB] FAIL rand_status key=%0d got unl=%b alm=%b fail=%0d expected %b %b %0d",
               k, bus.unlocked, bus.alarm, bus.fail_cnt, mOpen, mLockout, mFails);
    end
    testsRun++;
    if (okN !== eOk || errN !== eErr) begin
      testsFailed++;
      $display("[TB] FAIL rand_pulses key=%0d got ok=%0d err=%0d expected %0d %0d", k, okN, errN, eOk, eErr);
    end
    if (mLockout) begin
      repeat (LOCK + 5) @(negedge clk);
      mLockout = 0;
      mFails = 0;
    end
  endtask

  task automatic test_random();
    int r;
    applyReset();
    mDigits.delete();
    mCode = 'h1234;
    mOpen = 0;
    mLockout = 0;
    mFails = 0;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) randStep($urandom_range(0, 9));
      else if (r < 65) randStep(12);
      else if (r < 72) randStep(11);
      else if (r < 78) randStep(10);
      else if (r < 82) randStep($urandom_range(13, 15));
      else begin
        int c = mCode;
        for (int i = 3; i >= 0; i--) randStep((c >> (4 * i)) & 'hF);
        randStep(12);
      end
    end
  endtask

  initial begin
    bus.key_flag  = 1'b0;
    bus.key_value = 4'd0;
    test_reset();
    test_unlock();
    test_backspace();
    test_code_change();
    test_auto_relock();
    test_lockout();
    test_reset_mid_lockout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
